// File: rtl/kbd_pkg.sv
// kbd_pkg: shared decoder states and PS/2 scan-code constants.
package kbd_pkg;

    // Decoder states; PAUSE swallows the fixed-length Pause/Break tail.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } kbd_state_t;

    // Prefix bytes
    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_F0 = 8'hF0;
    localparam logic [7:0] PFX_E1 = 8'hE1;

    // Keyboard housekeeping bytes (BAT ok, ACK, echo, resend, errors)
    localparam logic [7:0] HK_BAT    = 8'hAA;
    localparam logic [7:0] HK_ACK    = 8'hFA;
    localparam logic [7:0] HK_ECHO   = 8'hEE;
    localparam logic [7:0] HK_RESEND = 8'hFE;
    localparam logic [7:0] HK_ERR0   = 8'h00;
    localparam logic [7:0] HK_ERR1   = 8'hFF;

    // Left and right shift make codes
    localparam logic [7:0] SHIFT_L = 8'h12;
    localparam logic [7:0] SHIFT_R = 8'h59;

    // Bytes following E1 in the Pause sequence
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    function automatic logic is_housekeeping(input logic [7:0] b);
        return (b == HK_BAT) || (b == HK_ACK) || (b == HK_ECHO) ||
               (b == HK_RESEND) || (b == HK_ERR0) || (b == HK_ERR1);
    endfunction

endpackage

// File: rtl/kbd_ascii_lut.sv
// kbd_ascii_lut: combinational scan-code set 2 to ASCII translation.
// Letters honour shift; digits, space, enter and backspace are fixed.
// Extended, break and unmapped codes translate to 0x00.
module kbd_ascii_lut
    import kbd_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       brk,
    input  logic       shift,
    output logic [7:0] ascii
);

    logic [7:0] lower;

    // Map a make code to its unshifted character.
    always_comb begin
        lower = 8'h00;
        case (code)
            8'h1C: lower = 8'h61; 8'h32: lower = 8'h62; 8'h21: lower = 8'h63;
            8'h23: lower = 8'h64; 8'h24: lower = 8'h65; 8'h2B: lower = 8'h66;
            8'h34: lower = 8'h67; 8'h33: lower = 8'h68; 8'h43: lower = 8'h69;
            8'h3B: lower = 8'h6A; 8'h42: lower = 8'h6B; 8'h4B: lower = 8'h6C;
            8'h3A: lower = 8'h6D; 8'h31: lower = 8'h6E; 8'h44: lower = 8'h6F;
            8'h4D: lower = 8'h70; 8'h15: lower = 8'h71; 8'h2D: lower = 8'h72;
            8'h1B: lower = 8'h73; 8'h2C: lower = 8'h74; 8'h3C: lower = 8'h75;
            8'h2A: lower = 8'h76; 8'h1D: lower = 8'h77; 8'h22: lower = 8'h78;
            8'h35: lower = 8'h79; 8'h1A: lower = 8'h7A;
            8'h45: lower = 8'h30; 8'h16: lower = 8'h31; 8'h1E: lower = 8'h32;
            8'h26: lower = 8'h33; 8'h25: lower = 8'h34; 8'h2E: lower = 8'h35;
            8'h36: lower = 8'h36; 8'h3D: lower = 8'h37; 8'h3E: lower = 8'h38;
            8'h46: lower = 8'h39;
            8'h29: lower = 8'h20; 8'h5A: lower = 8'h0D; 8'h66: lower = 8'h08;
            default: lower = 8'h00;
        endcase
    end

    // Apply shift to letters and suppress extended/break events.
    always_comb begin
        ascii = lower;
        if (ext || brk)
            ascii = 8'h00;
        else if (shift && lower >= 8'h61 && lower <= 8'h7A)
            ascii = lower - 8'h20;
    end

endmodule

// File: rtl/kbd_scan_decoder.sv
// kbd_scan_decoder: PS/2 scan-code byte stream to key events.
// Optional macro KBD_ASCII_EN adds a registered evt_ascii output.
//
// Event handshake: evt_valid stays high with evt_code/ext/brk stable until a
// cycle with evt_valid && evt_ready; that cycle transfers the event and may
// load a new one in the same edge. A new event arriving while the register is
// full and not being drained is dropped and sets the sticky overrun flag.
module kbd_scan_decoder
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic       shift,
`ifdef KBD_ASCII_EN
    output logic [7:0] evt_ascii,
`endif
    output logic       overrun,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    kbd_state_t       state_q, state_d;
    logic [2:0]       skip_q, skip_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gen_evt, gen_ext, gen_brk;
    logic [7:0]       gen_code;
    logic             to_fire;
    logic             from_idle;
    logic             shift_l, shift_r;
    logic             load;

    // BRK/EXT_BRK seeing E0/E1 is a protocol error: decode that byte afresh.
    assign from_idle = (state_q == ST_IDLE) ||
                       (((state_q == ST_BRK) || (state_q == ST_EXT_BRK)) &&
                        ((code_in == PFX_E0) || (code_in == PFX_E1)));

    // Next state, event generation and prefix timeout.
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        cnt_d    = cnt_q;
        gen_evt  = 1'b0;
        gen_code = code_in;
        gen_ext  = 1'b0;
        gen_brk  = 1'b0;
        to_fire  = 1'b0;
        if (code_valid) begin
            cnt_d = '0;
            if (state_q == ST_PAUSE) begin
                if (skip_q == 3'd1) begin
                    gen_evt  = 1'b1;
                    gen_code = PFX_E1;
                    state_d  = ST_IDLE;
                end else begin
                    skip_d = skip_q - 3'd1;
                end
            end else if (from_idle) begin
                state_d = ST_IDLE;
                if (code_in == PFX_E0)
                    state_d = ST_EXT;
                else if (code_in == PFX_F0)
                    state_d = ST_BRK;
                else if (code_in == PFX_E1) begin
                    state_d = ST_PAUSE;
                    skip_d  = PAUSE_SKIP;
                end else if (!is_housekeeping(code_in))
                    gen_evt = 1'b1;
            end else if (state_q == ST_EXT) begin
                if (code_in == PFX_F0)
                    state_d = ST_EXT_BRK;
                else if (code_in != PFX_E0) begin
                    gen_evt = 1'b1;
                    gen_ext = 1'b1;
                    state_d = ST_IDLE;
                end
            end else begin
                gen_evt = 1'b1;
                gen_ext = (state_q == ST_EXT_BRK);
                gen_brk = 1'b1;
                state_d = ST_IDLE;
            end
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                to_fire = 1'b1;
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Decoder state, pause skip count, timeout counter and pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            skip_q  <= 3'd0;
            cnt_q   <= '0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            timeout <= to_fire;
        end
    end

    // Shift tracking on every generated non-extended event, kept or dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_l <= 1'b0;
            shift_r <= 1'b0;
        end else if (gen_evt && !gen_ext) begin
            if (gen_code == SHIFT_L) shift_l <= !gen_brk;
            if (gen_code == SHIFT_R) shift_r <= !gen_brk;
        end
    end

    assign shift = shift_l | shift_r;
    assign load  = gen_evt && (!evt_valid || evt_ready);

`ifdef KBD_ASCII_EN
    logic [7:0] lut_ascii;

    kbd_ascii_lut u_ascii (
        .code  (gen_code),
        .ext   (gen_ext),
        .brk   (gen_brk),
        .shift (shift),
        .ascii (lut_ascii)
    );

    // ASCII travels with the event it was computed for.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            evt_ascii <= 8'h00;
        else if (load)
            evt_ascii <= lut_ascii;
    end
`endif

    // One-deep event holding register with sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_code  <= 8'h00;
            evt_ext   <= 1'b0;
            evt_brk   <= 1'b0;
            overrun   <= 1'b0;
        end else if (load) begin
            evt_valid <= 1'b1;
            evt_code  <= gen_code;
            evt_ext   <= gen_ext;
            evt_brk   <= gen_brk;
        end else begin
            if (gen_evt)
                overrun <= 1'b1;
            if (evt_ready)
                evt_valid <= 1'b0;
        end
    end

endmodule
